systolic_mvm_nxn: RTL
=====================

Name: systolic_mvm_nxn

Overview:
Parametrised weight-stationary N x N matrix-vector multiplier, successor to the fixed 4x4 4-bit array. It streams in an N x N weight matrix over a serial data port. Weights persist across vectors, so any number of N-element input vectors can be streamed without reloading. Each vector produces y[i] = sum_j W[i][j]*x[j], returned on a valid/ready result port with full backpressure.

Parameters:
N, 4, array dimension (rows = cols = N, N >= 2)
DW, 4, operand width of weights and inputs
AW, 2*DW+$clog2(N), accumulator/result width (default is overflow-free)

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
data_in  input  DW  weight or input-vector element
data_valid  input  1  data_in beat valid
data_ready  output  1  block accepts a beat (transfer = valid & ready)
load_weights  input  1  sampled on first beat only: 1 = weight stream, 0 = vector stream
res_data  output  N*AW  y[i] at bits [i*AW +: AW]
res_valid  output  1  res_data valid
res_ready  input  1  consumer accepts result
busy  output  1  high in any state except IDLE

Behaviour:
- One clock (clk); reset is synchronous and active-high. Any reset, including mid-stream, returns the FSM to IDLE and clears all of the following to 0:
  - weights, input buffer, accumulators, counters
  - res_data, res_valid, busy
  - data_ready goes to 1.
- FSM states: IDLE, LOAD_W, LOAD_X, COMPUTE, OUT.
- IDLE: data_ready=1.
  - Beat with load_weights=1: write W[0][0], cnt=1, go to LOAD_W.
  - Beat with load_weights=0: write x[0], cnt=1, go to LOAD_X.
- LOAD_W: data_ready=1. Weights arrive row-major; beat k writes W[k/N][k%N]. After beat N*N-1, return to IDLE. load_weights is ignored after the first beat.
- LOAD_X: data_ready=1. Beat k writes x[k]. After beat N-1, go to COMPUTE with column index c=0.
- Gaps (data_valid=0) in LOAD_W or LOAD_X stall the counter; there is no timeout.
- COMPUTE: data_ready=0. Runs for exactly N cycles; column c is broadcast to all rows.
  - c=0: acc[i] <= W[i][0]*x[0].
  - c>0: acc[i] <= acc[i] + W[i][c]*x[c].
  - After c=N-1, go to OUT.
- Latency: res_valid rises on the N-th clock edge after the edge that accepted the last x beat.
- OUT: res_valid=1, res_data=acc, data_ready=0. Outputs hold stable until res_valid & res_ready, then return to IDLE. res_valid drops on that same edge.
- Partial weight load then reset: weights are cleared, not partially retained.
- The same data beat never serves both a weight and a vector load.
- Arithmetic is unsigned by default. Products are DW*2 bits, zero-extended to AW. When AW is set below the default, results truncate modulo 2^AW with no saturation.
- A new vector can only start from IDLE. Back-to-back throughput is therefore N beats + N compute cycles + 1 OUT handshake cycle per vector.

Optional Feature:
SYSTOLIC_SIGNED_EN
- Defined: weights and inputs are two's complement. Products are signed and sign-extended to AW; res_data fields are two's complement.
- Undefined: unsigned arithmetic as above.
- Port list and timing are identical in both builds.

Decomposition:
- Package systolic_pkg holds:
  - state enum typedef (IDLE, LOAD_W, LOAD_X, COMPUTE, OUT)
  - function computing the default AW from DW and N
  - localparam defaults N_DEF=4, DW_DEF=4
- Sub-module systolic_row_mac (one per row, generated N times): holds that row's N weights and accumulator. Inputs: column index, x element, clear/accumulate enables. Output: acc. The top module owns the FSM, counters, input buffer and handshake.

Test Plan:
- Identity weights (W[i][i]=1, else 0), x=[1,2,3,4] -> res_data y=[1,2,3,4]; res_valid rises exactly 4 edges after the last x beat.
- All weights 15, x=[15,15,15,15] -> every y[i]=900 (AW=10, no overflow).
- Weight reuse: load W row i = [i+1,0,0,0], send x=[2,9,9,9] then x=[3,0,0,0] with no reload -> y=[2,4,6,8], then y=[3,6,9,12].
- Backpressure: hold res_ready=0 for 5 cycles in OUT -> res_valid and res_data stable, data_ready=0 throughout; releasing res_ready returns to IDLE in 1 edge.
- Reset asserted after 7 of 16 weight beats -> busy=0 and res_valid=0 next cycle; a following vector x=[5,5,5,5] yields y=[0,0,0,0].
- SYSTOLIC_SIGNED_EN build: all W=4'hF (-1), x=[1,2,3,4] -> every y[i] = -10 (10'h3F6).

Source files
------------

// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared state encoding, default sizes and width helper for the systolic MVM
package systolic_pkg;

  localparam int N_DEF  = 4;
  localparam int DW_DEF = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    LOAD_X,
    COMPUTE,
    OUT
  } state_t;

  // Overflow-free accumulator width: a full product plus one bit per doubling of terms.
  function automatic int default_aw(input int dw, input int n);
    return 2 * dw + $clog2(n);
  endfunction

endpackage

// File: rtl/systolic_row_mac.sv
// rtl/systolic_row_mac.sv - one array row: N stationary weights and a column-serial accumulator (SYSTOLIC_SIGNED_EN selects signed math)
module systolic_row_mac
  import systolic_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int DW = DW_DEF,
  parameter int AW = default_aw(DW_DEF, N_DEF)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  w_we,
  input  logic [((N > 1) ? $clog2(N) : 1)-1:0]  col,
  input  logic [DW-1:0]                         w_data,
  input  logic [DW-1:0]                         x,
  input  logic                                  acc_en,
  input  logic                                  acc_clr,
  output logic [AW-1:0]                         acc
);

  logic [DW-1:0] w [N];
  logic [DW-1:0] w_sel;
  logic [AW-1:0] prod_ext;

  assign w_sel = w[col];

`ifdef SYSTOLIC_SIGNED_EN
  // Operands are widened with their sign bit so the low 2*DW bits hold the exact signed product.
  logic signed [2*DW-1:0] prod;
  assign prod     = $signed({{DW{w_sel[DW-1]}}, w_sel}) * $signed({{DW{x[DW-1]}}, x});
  assign prod_ext = AW'(prod);
`else
  logic [2*DW-1:0] prod;
  assign prod     = {{DW{1'b0}}, w_sel} * {{DW{1'b0}}, x};
  assign prod_ext = AW'(prod);
`endif

  // Weight storage: written one column at a time while this row is selected during a weight load.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < N; j++) w[j] <= '0;
    end else if (w_we) begin
      w[col] <= w_data;
    end
  end

  // Accumulator: the first column restarts the sum, later columns add onto it.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
    end else if (acc_en) begin
      acc <= acc_clr ? prod_ext : acc + prod_ext;
    end
  end

endmodule

// File: rtl/systolic_mvm_nxn.sv
// rtl/systolic_mvm_nxn.sv - weight-stationary NxN matrix-vector multiplier top (optional SYSTOLIC_SIGNED_EN for two's complement)
module systolic_mvm_nxn
  import systolic_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int DW = DW_DEF,
  parameter int AW = default_aw(DW, N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [DW-1:0]   data_in,
  input  logic            data_valid,
  output logic            data_ready,
  input  logic            load_weights,
  output logic [N*AW-1:0] res_data,
  output logic            res_valid,
  input  logic            res_ready,
  output logic            busy
);

  localparam int CIW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CIW-1:0] LAST = CIW'(N - 1);

  state_t         state, state_n;
  logic [CIW-1:0] col;
  logic [CIW-1:0] row;
  logic [DW-1:0]  x_buf [N];
  logic [AW-1:0]  acc   [N];
  logic           wr_w;
  logic           wr_x;
  logic           mac_en;
  logic           mac_clr;

  assign busy    = (state != IDLE);
  assign mac_clr = (col == '0);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state and handshake decode; the first beat's load_weights picks the stream type.
  always_comb begin
    state_n    = state;
    data_ready = 1'b0;
    res_valid  = 1'b0;
    wr_w       = 1'b0;
    wr_x       = 1'b0;
    mac_en     = 1'b0;
    case (state)
      IDLE: begin
        data_ready = 1'b1;
        if (data_valid) begin
          if (load_weights) begin
            wr_w    = 1'b1;
            state_n = LOAD_W;
          end else begin
            wr_x    = 1'b1;
            state_n = LOAD_X;
          end
        end
      end
      LOAD_W: begin
        data_ready = 1'b1;
        if (data_valid) begin
          wr_w = 1'b1;
          if (row == LAST && col == LAST) state_n = IDLE;
        end
      end
      LOAD_X: begin
        data_ready = 1'b1;
        if (data_valid) begin
          wr_x = 1'b1;
          if (col == LAST) state_n = COMPUTE;
        end
      end
      COMPUTE: begin
        mac_en = 1'b1;
        if (col == LAST) state_n = OUT;
      end
      OUT: begin
        res_valid = 1'b1;
        if (res_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Column counter is shared by weight load, vector load and compute; it wraps to 0 at the end
  // of each phase so IDLE always starts at index 0. Row advances only on weight column wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (wr_w || wr_x || mac_en) begin
      col <= (col == LAST) ? '0 : col + CIW'(1);
      if (wr_w && col == LAST) row <= (row == LAST) ? '0 : row + CIW'(1);
    end
  end

  // Input vector buffer, held until the next vector overwrites it.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < N; j++) x_buf[j] <= '0;
    end else if (wr_x) begin
      x_buf[col] <= data_in;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    systolic_row_mac #(
      .N  (N),
      .DW (DW),
      .AW (AW)
    ) u_row (
      .clk     (clk),
      .reset   (reset),
      .w_we    (wr_w && (row == CIW'(i))),
      .col     (col),
      .w_data  (data_in),
      .x       (x_buf[col]),
      .acc_en  (mac_en),
      .acc_clr (mac_clr),
      .acc     (acc[i])
    );
    assign res_data[i*AW +: AW] = acc[i];
  end

endmodule
